// File: rtl/byte_collector_8_64.sv
// byte_collector_8_64: packs a strobed byte stream little-endian into 64-bit words buffered in a FWFT FIFO.
module byte_collector_8_64 #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready_in,
  output logic        req_data,
  input  logic        strobe_in,
  input  logic [7:0]  data_in,
  input  logic        data_end_in,
  output logic        out_valid,
  input  logic        out_rd,
  output logic [63:0] data_out,
  output logic [3:0]  byte_cnt,
  output logic        frame_end,
  output logic        overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [2:0]    idx_q;
  logic [63:0]   word_q, word_d;
  logic [68:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          done, full, pop, wr_en;
  always_comb begin
    word_d = word_q;
    word_d[{idx_q, 3'b000} +: 8] = data_in;
  end
  assign done  = strobe_in && (idx_q == 3'd7 || data_end_in);
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign pop   = out_rd && cnt_q != '0;
  assign wr_en = done && (!full || pop);
  assign out_valid = cnt_q != '0;
  assign {frame_end, byte_cnt, data_out} = out_valid ? mem_q[rd_q] : '0;
  // The shadow word is cleared on every completion, so unused upper lanes are already zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q    <= '0;
      word_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      req_data <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (strobe_in) begin
        idx_q  <= done ? 3'd0 : idx_q + 3'd1;
        word_q <= done ? '0 : word_d;
      end
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q    <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
      if (done && full && !pop) overflow <= 1'b1;
      req_data <= ready_in && cnt_q <= (AW+1)'(DEPTH - 2);
    end
  end
  always_ff @(posedge clk) if (wr_en) mem_q[wr_q] <= {data_end_in, {1'b0, idx_q} + 4'd1, word_d};
endmodule

// File: tb/tb_byte_collector_8_64.sv
// tb_byte_collector_8_64: directed and random checks of byte_collector_8_64 against a queue-based model.
module tb_byte_collector_8_64;
  localparam int DEPTH = 4;
  typedef struct {logic [63:0] w; logic [3:0] c; logic l;} ent_t;
  logic clk = 1'b0, reset, ready_in, req_data, strobe_in, data_end_in, out_valid, out_rd, frame_end, overflow;
  logic [7:0] data_in;
  logic [63:0] data_out;
  logic [3:0] byte_cnt;
  int n_chk = 0, n_fail = 0;
  ent_t mq[$];
  logic [7:0] cur[$];
  logic m_ovf, m_req;

  always #5 clk = ~clk;

  byte_collector_8_64 #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ready_in(ready_in), .req_data(req_data),
    .strobe_in(strobe_in), .data_in(data_in), .data_end_in(data_end_in),
    .out_valid(out_valid), .out_rd(out_rd), .data_out(data_out),
    .byte_cnt(byte_cnt), .frame_end(frame_end), .overflow(overflow)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    cur.delete();
    m_ovf = 1'b0;
    m_req = 1'b0;
  endtask

  task automatic model_step();
    int occ;
    ent_t e;
    logic do_pop;
    occ = mq.size();
    do_pop = out_rd && occ > 0;
    m_req = ready_in && (DEPTH - occ >= 2);
    if (do_pop) void'(mq.pop_front());
    if (strobe_in) begin
      cur.push_back(data_in);
      if (cur.size() == 8 || data_end_in) begin
        e.w = '0;
        foreach (cur[i]) e.w = e.w | (64'(cur[i]) << (8 * i));
        e.c = 4'(cur.size());
        e.l = data_end_in;
        if (occ < DEPTH || do_pop) mq.push_back(e);
        else m_ovf = 1'b1;
        cur.delete();
      end
    end
  endtask

  task automatic compare();
    logic [63:0] w;
    logic [3:0] c;
    logic l;
    w = '0; c = '0; l = 1'b0;
    if (mq.size() > 0) begin
      w = mq[0].w; c = mq[0].c; l = mq[0].l;
    end
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("data_out", data_out, w);
    chk("byte_cnt", 64'(byte_cnt), 64'(c));
    chk("frame_end", 64'(frame_end), 64'(l));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("req_data", 64'(req_data), 64'(m_req));
  endtask

  task automatic cyc(input logic s, input logic [7:0] d, input logic e, input logic rd, input logic rdy);
    strobe_in = s; data_in = d; data_end_in = e; out_rd = rd; ready_in = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic head(input string nm, input logic [63:0] w, input logic [3:0] c, input logic l);
    chk({nm, "_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_data"}, data_out, w);
    chk({nm, "_cnt"}, 64'(byte_cnt), 64'(c));
    chk({nm, "_end"}, 64'(frame_end), 64'(l));
  endtask

  initial begin
    reset = 1'b1; ready_in = 1'b1; strobe_in = 1'b0; data_in = '0; data_end_in = 1'b0; out_rd = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", data_out, 64'd0);
    chk("rst_req", 64'(req_data), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("req_after_release", 64'(req_data), 64'd1);
    // full 8-byte frame
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), i == 8, 1'b0, 1'b1);
    head("full", 64'h0807060504030201, 4'd8, 1'b1);
    chk("model_full", mq[0].w, 64'h0807060504030201);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("pop_empty", 64'(out_valid), 64'd0);
    // partial frame
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hCC, 1'b1, 1'b0, 1'b1);
    head("partial", 64'h0000000000CCBBAA, 4'd3, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    // multi-word frame, end without strobe must be ignored
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b1, 8'(8'h10 + i), i == 11, 1'b0, 1'b1);
    head("multi0", 64'h1716151413121110, 4'd8, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    head("multi1", 64'h000000001B1A1918, 4'd4, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    // fill, overflow, push+pop while full
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0, 1'b1);
    chk("req_drop_full", 64'(req_data), 64'd0);
    chk("no_ovf_yet", 64'(overflow), 64'd0);
    cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
    chk("ovf_set", 64'(overflow), 64'd1);
    head("ovf_head", 64'h00000000000000A0, 4'd1, 1'b1);
    cyc(1'b1, 8'hF0, 1'b1, 1'b1, 1'b1);
    head("pushpop_head", 64'h00000000000000A1, 4'd1, 1'b1);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("last_pushed", 64'(mq.size()), 64'd0);
    // reset mid-frame discards partial word
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b1);
    strobe_in = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_ovf", 64'(overflow), 64'd0);
    chk("midrst_req", 64'(req_data), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_cnt", 64'(byte_cnt), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h66, 1'b1, 1'b0, 1'b1);
    head("after_rst", 64'h0000000000006655, 4'd2, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(3) != 0, 8'($urandom), $urandom_range(5) == 0, $urandom_range(1) == 1, $urandom_range(4) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
